// File: rtl/out_port_sequencer_if.sv
// Request/ack and latch-strobe bundle of the output-port sequencer.
//   master : requesters A/B (req, data, mask), hold source; observes acks and strobes
//   slave  : the sequencer; drives acks, sel_* strobes and busy
interface out_port_sequencer_if #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned ADDR_W = 3
) ();
  logic              a_req;
  logic [NBITS-1:0]  a_data;
  logic [NBITS-1:0]  a_mask;
  logic              a_ack;
  logic              b_req;
  logic [NBITS-1:0]  b_data;
  logic [NBITS-1:0]  b_mask;
  logic              b_ack;
  logic              hold;
  logic              sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic              sel_ce;
  logic              busy;

  modport master (
    output a_req, a_data, a_mask, b_req, b_data, b_mask, hold,
    input  a_ack, b_ack, sel_data, sel_addr, sel_write, sel_ce, busy
  );

  modport slave (
    input  a_req, a_data, a_mask, b_req, b_data, b_mask, hold,
    output a_ack, b_ack, sel_data, sel_addr, sel_write, sel_ce, busy
  );
endinterface

// File: rtl/out_port_sequencer.sv
// Output-port sequencer: round-robin arbitration between requesters A and B,
// then serialises the granted masked byte into one latch strobe per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : out_port_sequencer_if.slave (requests, acks, sel_* strobes, hold, busy)
// Build option:
//   OUTSEQ_SKIP_EN : when defined, SHIFT visits only set mask bits (ascending);
//                    when undefined, every bit index 0..NBITS-1 is scanned.
module out_port_sequencer #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  out_port_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0]  data_q, data_d;
  logic [NBITS-1:0]  mask_q, mask_d;
  logic              gnt_b_q, gnt_b_d;   // last/current grant: 1 = B, 0 = A
  logic              take_b;
  logic              in_shift;

`ifdef OUTSEQ_SKIP_EN
  // Lowest set bit of m (0 when m is empty)
  function automatic logic [ADDR_W-1:0] first_set(input logic [NBITS-1:0] m);
    first_set = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (m[i]) first_set = ADDR_W'(i);
    end
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      gnt_b_q <= 1'b1;   // B counts as last grant so A wins the first tie
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    gnt_b_d = gnt_b_q;
    take_b  = 1'b0;
    case (state_q)
      IDLE: begin
        take_b = bus.b_req && (!bus.a_req || !gnt_b_q);
        if (bus.a_req || bus.b_req) begin
          gnt_b_d = take_b;
          data_d  = take_b ? bus.b_data : bus.a_data;
          mask_d  = take_b ? bus.b_mask : bus.a_mask;
`ifdef OUTSEQ_SKIP_EN
          idx_d   = first_set(mask_d);
`else
          idx_d   = '0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // An empty mask spends exactly one SHIFT cycle, then acks
        if (mask_q == '0) begin
          state_d = DONE;
        end else if (!bus.hold) begin
`ifdef OUTSEQ_SKIP_EN
          mask_d = mask_q & ~(NBITS'(1) << idx_q);
          if (mask_d == '0) state_d = DONE;
          else              idx_d   = first_set(mask_d);
`else
          if (idx_q == ADDR_W'(NBITS - 1)) state_d = DONE;
          else                             idx_d   = idx_q + ADDR_W'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; hold gates the strobes within the same cycle
  assign in_shift      = (state_q == SHIFT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.a_ack     = (state_q == DONE) && !gnt_b_q;
  assign bus.b_ack     = (state_q == DONE) && gnt_b_q;
  assign bus.sel_addr  = in_shift ? idx_q : '0;
  assign bus.sel_data  = in_shift && data_q[idx_q];
  assign bus.sel_ce    = in_shift && !bus.hold;
  assign bus.sel_write = in_shift && mask_q[idx_q] && !bus.hold;

endmodule
